load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, max cycles waited in REQ or WAIT_R before abort (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  datapath requests memory access (memread or memwrite of current instruction).
REQ-005 req_we  input  1  1 = store, 0 = load; sampled with req_valid.
REQ-006 addr  input  32  byte address from ALU result.
REQ-007 wdata  input  32  store data (register rt value).
REQ-008 stall  output  1  holds datapath and PC while access in flight.
REQ-009 rdata  output  32  load data to writeback mux.
REQ-010 err  output  1  access aborted (timeout or misalign).
REQ-011 mem_req  output  1  request to data memory.
REQ-012 mem_we  output  1  write enable to memory.
REQ-013 mem_addr  output  32  word-aligned memory address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_gnt  input  1  memory accepts request.
REQ-016 mem_rvalid  input  1  read data valid.
REQ-017 mem_rdata  input  32  read data from memory.

Function
REQ-018 FSM states IDLE, REQ, WAIT_R, DONE; all outputs except stall registered.
REQ-019 IDLE: req_valid=1 -> latch req_we, addr, wdata; next state REQ; timeout counter cleared.
REQ-020 stall = req_valid AND state != DONE (combinational); stall=0 whenever req_valid=0.
REQ-021 REQ: mem_req=1, mem_we=latched we, mem_addr={addr[31:2],2'b00}, mem_wdata=latched wdata, all stable until mem_gnt.
REQ-022 REQ with mem_gnt=1: store -> DONE; load -> WAIT_R; mem_req deasserts next cycle.
REQ-023 WAIT_R with mem_rvalid=1: rdata <= mem_rdata; next DONE.
REQ-024 mem_rvalid ignored outside WAIT_R; mem_gnt ignored outside REQ.
REQ-025 Timeout counter increments each cycle in REQ/WAIT_R without progress; on reaching TIMEOUT_CYCLES -> DONE, err=1, rdata=0, mem_req dropped.
REQ-026 DONE: lasts exactly one cycle, stall=0, rdata held; err=1 only if aborted; next IDLE.
REQ-027 rdata holds last value until next load completion or abort; stores leave rdata unchanged.
REQ-028 Latency (gnt in first REQ cycle): store releases stall 2 cycles after req_valid rises; load with rvalid one cycle after gnt releases stall after 3 cycles.
REQ-029 Input changes on addr/wdata/req_we after IDLE capture have no effect on the in-flight access.

Reset
REQ-030 reset=1 forces IDLE immediately, independent of clk, including mid-access.
REQ-031 Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, err=0, counter=0.
REQ-032 A late mem_rvalid/mem_gnt after reset release is ignored (state IDLE).

Configuration
REQ-033 Macro LSU_ALIGN_CHECK_EN defined: IDLE with req_valid=1 and addr[1:0]!=0 -> DONE directly, err=1, no mem_req, rdata=0 for loads, no write for stores.
REQ-034 LSU_ALIGN_CHECK_EN undefined: addr[1:0] ignored, access proceeds to word address, err only on timeout.

Verification
REQ-035 Store addr=0x0000_0010 wdata=0xCAFE_F00D, gnt in first REQ cycle -> mem_addr=0x10, mem_we=1, stall low exactly 2 cycles after req_valid, err=0.
REQ-036 Load addr=0x0000_0024, gnt after 3 cycles, rvalid 2 cycles later with 0x1234_5678 -> rdata=0x1234_5678 in DONE, stall high until DONE.
REQ-037 Load with mem_gnt held 0, TIMEOUT_CYCLES=4 -> DONE after 4 REQ cycles, err=1 one cycle, rdata=0.
REQ-038 reset pulsed asynchronously in WAIT_R, then rvalid=1 -> mem_req=0 immediately, state IDLE, rdata stays 0.
REQ-039 Load addr=0x0000_0006 -> with LSU_ALIGN_CHECK_EN: no mem_req, err=1; without: mem_addr=0x4, normal completion.
REQ-040 Back-to-back load then store -> second access captured in IDLE cycle after DONE, no dropped or duplicated request.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the data memory.
//   master : LSU side   -- drives mem_req/mem_we/mem_addr/mem_wdata, receives gnt/rvalid/rdata
//   slave  : memory side -- the mirror image
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns a datapath memory request into a single word access on the
// data-memory bus, stalling the datapath until the access completes or is aborted.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   req_valid/req_we  access request from the datapath (1 = store, 0 = load)
//   addr, wdata       byte address and store data, captured when the access starts
//   stall             combinational hold for the datapath/PC while an access is in flight
//   rdata, err        load result and abort flag (err is high for the one DONE cycle)
//   mem               data-memory bus (master side)
//
// Parameter TIMEOUT_CYCLES (1..255): cycles waited in REQ, and again in WAIT_R, before abort.
// Optional macro LSU_ALIGN_CHECK_EN: reject accesses with addr[1:0] != 0 without touching memory.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      stall,
  output logic [31:0]               rdata,
  output logic                      err,
  load_store_unit_if.master         mem
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  // mem_we/mem_addr/mem_wdata double as the latched request fields.
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
          if (addr[1:0] != 2'b00) begin
            // Misaligned: abort without a bus access; only loads lose rdata.
            state_d = StDone;
            err_d   = 1'b1;
            if (!req_we) begin
              rdata_d = '0;
            end
          end else
`endif
          begin
            state_d     = StReq;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = addr & 32'hFFFF_FFFC;
            mem_wdata_d = wdata;
          end
        end
      end

      StReq: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;  // WAIT_R gets its own timeout budget
          state_d   = mem_we_q ? StDone : StWaitR;
        end else if (cnt_q == CntLast) begin
          mem_req_d = 1'b0;
          state_d   = StDone;
          err_d     = 1'b1;
          rdata_d   = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StWaitR: begin
        if (mem.mem_rvalid) begin
          rdata_d = mem.mem_rdata;
          state_d = StDone;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // DONE releases the datapath; outside an access stall is always low.
  assign stall         = req_valid && (state_q != StDone);
  assign rdata         = rdata_q;
  assign err           = err_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected completions and bus
// requests into queues, independent monitors pop and compare them.
module tb_load_store_unit;
  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // cycles stall stays high from the first req_valid cycle
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int          g;     // REQ cycles without grant before granting
    int          r;     // WAIT_R cycles without rvalid before data
    logic [31:0] d;
    bit          we;
  } plan_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        err;

  load_store_unit_if mem_if ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .err       (err),
    .mem       (mem_if)
  );

  exp_t        exp_q[$];
  mem_exp_t    mem_q[$];
  plan_t       plan_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          resp_en = 0;
  logic [31:0] last_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event required none", name);
  endtask

  // Memory responder: follows the per-access plan, and throws a late gnt/rvalid into
  // the DONE cycle after a timeout, which the DUT must ignore.
  initial begin
    plan_t p;
    int    c;
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        if (mem_if.mem_req) begin
          if (plan_q.size() == 0) begin
            flag("unplanned_mem_req");
          end else begin
            p = plan_q.pop_front();
            c = 0;
            while (mem_if.mem_req && c < p.g) begin
              @(posedge clk);
              #1;
              c++;
            end
            if (mem_if.mem_req) begin
              mem_if.mem_gnt = 1'b1;
              @(posedge clk);
              #1;
              mem_if.mem_gnt = 1'b0;
              if (!p.we) begin
                repeat ((p.r < TO) ? p.r : TO) begin
                  @(posedge clk);
                  #1;
                end
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = (p.r < TO) ? p.d : $urandom();
              end
            end else begin
              mem_if.mem_gnt = 1'b1;
            end
          end
        end
      end
    end
  end

  // Bus monitor: each accepted request must match the next expected one.
  initial begin
    mem_exp_t m;
    forever begin
      @(negedge clk);
      if (mem_if.mem_req && mem_if.mem_gnt) begin
        if (mem_q.size() == 0) begin
          flag("unexpected_mem_handshake");
        end else begin
          m = mem_q.pop_front();
          chk("mem_addr", mem_if.mem_addr, m.addr);
          chk("mem_we", {31'd0, mem_if.mem_we}, {31'd0, m.we});
          chk("mem_wdata", mem_if.mem_wdata, m.wdata);
        end
      end
    end
  end

  // Completion monitor: stall falling with req_valid high marks the DONE cycle.
  initial begin
    exp_t e;
    int   cyc = 0;
    forever begin
      @(negedge clk);
      if (!req_valid) begin
        chk("stall_idle", {31'd0, stall}, 32'd0);
        cyc = 0;
      end else if (stall) begin
        cyc++;
        chk("err_in_flight", {31'd0, err}, 32'd0);
      end else begin
        if (exp_q.size() == 0) begin
          flag("unexpected_completion");
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("stall_cycles", 32'(cyc), 32'(e.lat));
        end
        cyc = 0;
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int r, input logic [31:0] d, input int gap);
    exp_t     e;
    mem_exp_t m;
    plan_t    p;
    bit       misal;
    int       n;
    misal = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misal = (a[1:0] != 2'b00);
`endif
    if (misal) begin
      e.err   = 1'b1;
      e.rdata = we ? last_rdata : 32'd0;
      e.lat   = 1;
    end else begin
      m.addr  = {a[31:2], 2'b00};
      m.we    = we;
      m.wdata = wd;
      p.g = g; p.r = r; p.d = d; p.we = we;
      if (g < TO) mem_q.push_back(m);
      plan_q.push_back(p);
      if (g >= TO) begin
        e.err = 1'b1; e.rdata = 32'd0; e.lat = 1 + TO;
      end else if (we) begin
        e.err = 1'b0; e.rdata = last_rdata; e.lat = 2 + g;
      end else if (r >= TO) begin
        e.err = 1'b1; e.rdata = 32'd0; e.lat = 2 + g + TO;
      end else begin
        e.err = 1'b0; e.rdata = d; e.lat = 3 + g + r;
      end
    end
    last_rdata = e.rdata;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (gap > 0) begin
      req_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    req_valid = 1'b1;
    req_we    = we;
    addr      = a;
    wdata     = wd;

    @(negedge clk);
    n = 0;
    while (stall) begin
      // Inputs may wander once captured; the in-flight access must not notice.
      if (n > 0) begin
        req_we = $urandom_range(0, 1) == 1;
        addr   = $urandom();
        wdata  = $urandom();
      end
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL completion_wait: got no DONE after %0d cycles required DONE", n);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "access never completed");
      end
    end
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 7) == 0) return TO + $urandom_range(0, 1);
    return $urandom_range(0, TO - 1);
  endfunction

  initial begin
    mem_exp_t m;
    logic [31:0] a;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    addr      = '0;
    wdata     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_if.mem_we}, 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    // Asynchronous reset in WAIT_R, then a late rvalid/gnt that must be ignored.
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; addr = 32'h40; wdata = 32'h5555_AAAA;
    m.addr = 32'h40; m.we = 1'b0; m.wdata = 32'h5555_AAAA;
    mem_q.push_back(m);
    @(posedge clk);
    #1;
    chk("rst_test_req", {31'd0, mem_if.mem_req}, 32'd1);
    mem_if.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_if.mem_gnt = 1'b0;
    chk("rst_test_req_drop", {31'd0, mem_if.mem_req}, 32'd0);
    #3;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("async_rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("async_rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'hDEAD_BEEF;
    mem_if.mem_gnt    = 1'b1;
    @(posedge clk);
    #1;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_gnt    = 1'b0;
    chk("late_rvalid_rdata", rdata, 32'd0);
    chk("late_rvalid_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    chk("late_rvalid_err", {31'd0, err}, 32'd0);

    resp_en = 1'b1;
    issue(1'b1, 32'h10, 32'hCAFE_F00D, 0, 0, 32'h0, 1);
    issue(1'b0, 32'h24, 32'h0BAD_0BAD, 3, 1, 32'h1234_5678, 1);
    issue(1'b0, 32'h80, 32'h0, TO + 2, 0, 32'h7777_7777, 1);
    issue(1'b0, 32'h6, 32'h0, 0, 0, 32'hA5A5_5A5A, 1);
    issue(1'b1, 32'h3, 32'h1111_2222, 1, 0, 32'h0, 0);
    issue(1'b0, 32'h50, 32'h0, 0, TO, 32'h3333_3333, 1);
    issue(1'b0, 32'h30, 32'h0, 1, 0, 32'h0F0F_F0F0, 1);
    issue(1'b1, 32'h34, 32'h9999_8888, 0, 0, 32'h0, 0);
    issue(1'b0, 32'h38, 32'h0, 0, 0, 32'h2468_ACE0, 0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue($urandom_range(0, 1) == 1, a, $urandom(), rand_delay(), rand_delay(), $urandom(),
            $urandom_range(0, 2));
    end

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (TO + 4) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("plan_q_drained", plan_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
